// File: rtl/cpu_fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage: tag width, control-transfer
// opcodes and the fetch FSM state encoding.
package cpu_fetch_unit_pkg;

    localparam int FETCH_TAG_WIDTH = 4;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ST_REQ   = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_JUMP  = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    function automatic logic is_ctrl_op(input logic [6:0] opcode);
        return (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/cpu_fetch_unit_prefetch_buffer.sv
// Single-entry speculative fetch buffer (valid, data, address) used only when
// CPU_FETCH_PREFETCH_EN is defined; tracks one in-flight speculative read.
module cpu_fetch_prefetch_buffer (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        launch_i,
    input  logic        adopt_i,
    input  logic        flush_i,
    input  logic        consume_i,
    input  logic        fill_i,
    input  logic [31:0] fill_data_i,
    input  logic [31:0] fill_addr_i,
    output logic        pending_o,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic [31:0] addr_o
);

    logic        pending_q;
    logic        discard_q;
    logic        valid_q;
    logic [31:0] data_q;
    logic [31:0] addr_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pending_q <= 1'b0;
            discard_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
        end else begin
            if (launch_i) begin
                pending_q <= 1'b1;
                discard_q <= 1'b0;
                addr_q    <= fill_addr_i;
            end else if (pending_q && (fill_i || adopt_i)) begin
                pending_q <= 1'b0;
                discard_q <= 1'b0;
            end
            // A flushed read still has to complete on the bus, but its data is dropped.
            if (pending_q && fill_i && !discard_q && !adopt_i && !flush_i) begin
                valid_q <= 1'b1;
                data_q  <= fill_data_i;
            end else if (flush_i || consume_i) begin
                valid_q <= 1'b0;
            end
            if (flush_i && pending_q && !fill_i) begin
                discard_q <= 1'b1;
            end
        end
    end

    assign pending_o = pending_q;
    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign addr_o    = addr_q;

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage feeding decode over the tag interface.
// Optional one-entry prefetch enabled by defining CPU_FETCH_PREFETCH_EN.
//
// state    | meaning
// ST_REQ   | launch bus read at pc (fault if misaligned)
// ST_WAIT  | read outstanding, hold request/address
// ST_ISSUE | instruction presented, wait for decode to consume it
// ST_JUMP  | control transfer issued, wait for execute's resolved pc
// ST_HALT  | misaligned pc seen, terminal until reset
module cpu_fetch_unit
    import cpu_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          TAG_WIDTH = FETCH_TAG_WIDTH
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    output logic                 o_bus_request,
    output logic [31:0]          o_bus_address,
    input  logic                 i_bus_ready,
    input  logic [31:0]          i_bus_rdata,
    input  logic [TAG_WIDTH-1:0] i_decode_tag,
    input  logic                 i_stall,
    input  logic                 i_jump_valid,
    input  logic [TAG_WIDTH-1:0] i_jump_tag,
    input  logic [31:0]          i_jump_pc,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic [31:0]          o_instruction,
    output logic [31:0]          o_pc,
    output logic                 o_fault
);

    logic [2:0]           state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [31:0]          insn_q, insn_d;
    logic [31:0]          ipc_q, ipc_d;
    logic [31:0]          addr_q, addr_d;
    logic                 req_q, req_d;
    logic                 fault_q, fault_d;
    logic                 consumed;
    logic                 jump_hit;

    assign consumed = (i_decode_tag == tag_q) && !i_stall;
    assign jump_hit = i_jump_valid && (i_jump_tag == tag_q);

`ifdef CPU_FETCH_PREFETCH_EN
    logic        pf_launch, pf_adopt, pf_flush, pf_consume;
    logic        pf_pending, pf_valid;
    logic [31:0] pf_data, pf_addr;

    cpu_fetch_prefetch_buffer u_prefetch (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .launch_i    (pf_launch),
        .adopt_i     (pf_adopt),
        .flush_i     (pf_flush),
        .consume_i   (pf_consume),
        .fill_i      (i_bus_ready),
        .fill_data_i (i_bus_rdata),
        .fill_addr_i (pc_q + 32'd4),
        .pending_o   (pf_pending),
        .valid_o     (pf_valid),
        .data_o      (pf_data),
        .addr_o      (pf_addr)
    );
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tag_d   = tag_q;
        insn_d  = insn_q;
        ipc_d   = ipc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        fault_d = fault_q;
`ifdef CPU_FETCH_PREFETCH_EN
        pf_launch  = 1'b0;
        pf_adopt   = 1'b0;
        pf_flush   = 1'b0;
        pf_consume = 1'b0;
        if (pf_pending && i_bus_ready) req_d = 1'b0;
`endif
        case (state_q)
            ST_REQ: begin
                if (pc_q[1:0] != 2'b00) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end
`ifdef CPU_FETCH_PREFETCH_EN
                else if (pf_pending) begin
                    state_d = ST_REQ;
                end
`endif
                else begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_bus_ready) begin
                    req_d   = 1'b0;
                    insn_d  = i_bus_rdata;
                    ipc_d   = pc_q;
                    tag_d   = tag_q + 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
`ifdef CPU_FETCH_PREFETCH_EN
                if (!consumed && !is_ctrl_op(insn_q[6:0]) && !pf_valid && !pf_pending && !req_q) begin
                    pf_launch = 1'b1;
                    req_d     = 1'b1;
                    addr_d    = pc_q + 32'd4;
                end
`endif
                if (consumed) begin
                    if (is_ctrl_op(insn_q[6:0])) begin
                        state_d = ST_JUMP;
`ifdef CPU_FETCH_PREFETCH_EN
                        pf_flush = 1'b1;
`endif
                    end else begin
                        pc_d = pc_q + 32'd4;
`ifdef CPU_FETCH_PREFETCH_EN
                        if (pf_valid) begin
                            insn_d     = pf_data;
                            ipc_d      = pf_addr;
                            tag_d      = tag_q + 1'b1;
                            pf_consume = 1'b1;
                        end else if (pf_pending && i_bus_ready) begin
                            insn_d   = i_bus_rdata;
                            ipc_d    = pc_q + 32'd4;
                            tag_d    = tag_q + 1'b1;
                            pf_adopt = 1'b1;
                        end else if (pf_pending) begin
                            // The speculative read becomes the demand read; never re-issued.
                            pf_adopt = 1'b1;
                            state_d  = ST_WAIT;
                        end else begin
                            state_d = ST_REQ;
                        end
`else
                        state_d = ST_REQ;
`endif
                    end
                end
            end
            ST_JUMP: begin
                if (jump_hit) begin
                    pc_d    = i_jump_pc;
                    state_d = ST_REQ;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            tag_q   <= '0;
            insn_q  <= '0;
            ipc_q   <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
            insn_q  <= insn_d;
            ipc_q   <= ipc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            fault_q <= fault_d;
        end
    end

    assign o_bus_request = req_q;
    assign o_bus_address = addr_q;
    assign o_tag         = tag_q;
    assign o_instruction = insn_q;
    assign o_pc          = ipc_q;
    assign o_fault       = fault_q;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Self-checking bench for cpu_fetch_unit: transaction-level model of the fetch
// stream (expected addresses, tags, presented words) plus directed literal checks.
`timescale 1ns/1ps
module tb_cpu_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          TW     = 4;

    logic          i_clock = 1'b0;
    logic          i_reset;
    logic          o_bus_request;
    logic [31:0]   o_bus_address;
    logic          i_bus_ready;
    logic [31:0]   i_bus_rdata;
    logic [TW-1:0] i_decode_tag;
    logic          i_stall;
    logic          i_jump_valid;
    logic [TW-1:0] i_jump_tag;
    logic [31:0]   i_jump_pc;
    logic [TW-1:0] o_tag;
    logic [31:0]   o_instruction;
    logic [31:0]   o_pc;
    logic          o_fault;

    always #5 i_clock = ~i_clock;

    cpu_fetch_unit #(.RESET_PC(RST_PC), .TAG_WIDTH(TW)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .o_bus_request (o_bus_request),
        .o_bus_address (o_bus_address),
        .i_bus_ready   (i_bus_ready),
        .i_bus_rdata   (i_bus_rdata),
        .i_decode_tag  (i_decode_tag),
        .i_stall       (i_stall),
        .i_jump_valid  (i_jump_valid),
        .i_jump_tag    (i_jump_tag),
        .i_jump_pc     (i_jump_pc),
        .o_tag         (o_tag),
        .o_instruction (o_instruction),
        .o_pc          (o_pc),
        .o_fault       (o_fault)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: where the stream is, what fetch should ask for next, what decode should see.
    localparam int P_FETCH = 0, P_ISSUE = 1, P_JUMP = 2, P_HALT = 3;
    int            ph;
    logic [31:0]   m_addr, m_instr, m_pc;
    logic [TW-1:0] m_tag;
    bit            req_open, bad_sent;
    int            bus_wait, idle, jwait;

    int          max_bus_delay, stall_pct, jump_delay_max;
    bit          bad_jump, hold_decode, hold_bus, plain_nop, ctrl_mix, jump_rand;
    logic [31:0] ovr_addr, ovr_word, jump_target;

    logic [31:0]   log_addr[$];
    logic [31:0]   log_pc[$];
    logic [31:0]   log_instr[$];
    logic [TW-1:0] log_tag[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_ctrl(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        return (op == 7'h6F) || (op == 7'h67) || (op == 7'h63);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == ovr_addr) return ovr_word;
        if (plain_nop) return 32'h0000_0013;
        if (ctrl_mix && a[4:2] == 3'd5) return {a[31:7] ^ 25'h0015a5a, 7'b1100011};
        if (ctrl_mix && a[4:2] == 3'd6) return {a[31:7], 7'b1100111};
        return {a[26:2], 7'b0010011};
    endfunction

    task automatic model_reset();
        ph       = P_FETCH;
        m_addr   = RST_PC;
        m_instr  = '0;
        m_pc     = '0;
        m_tag    = '0;
        req_open = 1'b0;
        bad_sent = 1'b0;
        bus_wait = 0;
        idle     = 0;
        jwait    = 0;
        log_addr.delete();
        log_pc.delete();
        log_instr.delete();
        log_tag.delete();
    endtask

    task automatic drive_defaults();
        i_bus_ready  = 1'b0;
        i_bus_rdata  = $urandom;
        i_jump_valid = ($urandom_range(0, 3) == 0);
        i_jump_tag   = TW'($urandom);
        i_jump_pc    = $urandom;
        i_stall      = 1'($urandom_range(0, 1));
        i_decode_tag = TW'(m_tag - 1'b1);
    endtask

    task automatic step();
        logic [31:0] w;
        @(negedge i_clock);
        chk("o_tag", 32'(o_tag), 32'(m_tag));
        chk("o_instruction", o_instruction, m_instr);
        chk("o_pc", o_pc, m_pc);
        case (ph)
            P_FETCH: begin
                if (m_addr[1:0] != 2'b00) begin
                    chk("no_req_misaligned", 32'(o_bus_request), 32'd0);
                    if (o_fault) ph = P_HALT;
                    else if (++idle > 4) begin
                        chk("fault_timeout", 32'(o_fault), 32'd1);
                        ph = P_HALT;
                    end
                end else begin
                    chk("fault_low", 32'(o_fault), 32'd0);
                    if (o_bus_request) begin
                        chk(req_open ? "addr_hold" : "req_addr", o_bus_address, m_addr);
                        if (!req_open) begin
                            req_open = 1'b1;
                            bus_wait = $urandom_range(0, max_bus_delay);
                            log_addr.push_back(o_bus_address);
                        end
                    end else if (req_open) begin
                        chk("req_dropped", 32'(o_bus_request), 32'd1);
                        req_open = 1'b0;
                    end else if (++idle > 4) begin
                        chk("req_timeout", 32'(o_bus_request), 32'd1);
                        idle = 0;
                    end
                end
            end
            P_ISSUE, P_JUMP: begin
                chk("no_req", 32'(o_bus_request), 32'd0);
                chk("fault_low", 32'(o_fault), 32'd0);
            end
            default: begin
                chk("halt_fault", 32'(o_fault), 32'd1);
                chk("halt_no_req", 32'(o_bus_request), 32'd0);
            end
        endcase

        drive_defaults();
        case (ph)
            P_FETCH: begin
                if (req_open && !hold_bus) begin
                    if (bus_wait == 0) begin
                        w           = mem_word(m_addr);
                        i_bus_ready = 1'b1;
                        i_bus_rdata = w;
                        m_tag       = TW'(m_tag + 1'b1);
                        m_instr     = w;
                        m_pc        = m_addr;
                        log_pc.push_back(m_addr);
                        log_instr.push_back(w);
                        log_tag.push_back(m_tag);
                        req_open    = 1'b0;
                        ph          = P_ISSUE;
                    end else begin
                        bus_wait--;
                    end
                end
            end
            P_ISSUE: begin
                i_jump_valid = 1'b0;
                if (hold_decode) begin
                    i_stall      = 1'b1;
                    i_decode_tag = TW'(m_tag - 1'b1);
                end else if ($urandom_range(0, 99) < stall_pct) begin
                    if ($urandom_range(0, 1) == 1) begin
                        i_stall      = 1'b1;
                        i_decode_tag = m_tag;
                    end else begin
                        i_decode_tag = TW'(m_tag + $urandom_range(1, 15));
                    end
                end else begin
                    i_stall      = 1'b0;
                    i_decode_tag = m_tag;
                    idle         = 0;
                    if (is_ctrl(m_instr)) begin
                        ph       = P_JUMP;
                        jwait    = $urandom_range(0, jump_delay_max);
                        bad_sent = 1'b0;
                    end else begin
                        m_addr = m_addr + 32'd4;
                        ph     = P_FETCH;
                    end
                end
            end
            P_JUMP: begin
                if (jwait > 0) begin
                    jwait--;
                    i_jump_valid = 1'($urandom_range(0, 1));
                    i_jump_tag   = TW'(m_tag + $urandom_range(1, 15));
                end else if (bad_jump && !bad_sent) begin
                    i_jump_valid = 1'b1;
                    i_jump_tag   = TW'(m_tag + 1'b1);
                    i_jump_pc    = 32'h0000_0200;
                    bad_sent     = 1'b1;
                end else begin
                    i_jump_valid = 1'b1;
                    i_jump_tag   = m_tag;
                    i_jump_pc    = jump_rand ? {20'h0, 10'($urandom_range(0, 1023)), 2'b00} : jump_target;
                    m_addr       = i_jump_pc;
                    idle         = 0;
                    ph           = P_FETCH;
                end
            end
            default: begin
                i_bus_ready  = 1'($urandom_range(0, 1));
                i_jump_valid = 1'b1;
                i_jump_tag   = m_tag;
                i_jump_pc    = RST_PC;
                i_stall      = 1'b0;
                i_decode_tag = m_tag;
            end
        endcase
    endtask

    task automatic apply_reset(input bit ready_too);
        i_reset = 1'b1;
        if (ready_too) begin
            i_bus_ready = 1'b1;
            i_bus_rdata = 32'hDEAD_BEEF;
        end
        @(negedge i_clock);
        chk("rst_request", 32'(o_bus_request), 32'd0);
        chk("rst_address", o_bus_address, 32'd0);
        chk("rst_tag", 32'(o_tag), 32'd0);
        chk("rst_instruction", o_instruction, 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_fault", 32'(o_fault), 32'd0);
        i_reset = 1'b0;
        model_reset();
        drive_defaults();
    endtask

    task automatic run_until(input int n, input int budget);
        int c;
        c = 0;
        while (log_pc.size() < n && c < budget) begin
            step();
            c++;
        end
        if (log_pc.size() < n) chk("progress_timeout", 32'(log_pc.size()), 32'(n));
    endtask

    initial begin
        max_bus_delay  = 0;
        stall_pct      = 0;
        jump_delay_max = 0;
        bad_jump       = 1'b0;
        hold_decode    = 1'b0;
        hold_bus       = 1'b0;
        plain_nop      = 1'b1;
        ctrl_mix       = 1'b0;
        jump_rand      = 1'b0;
        ovr_addr       = 32'hFFFF_FFFF;
        ovr_word       = 32'h0;
        jump_target    = 32'h0;
        model_reset();
        drive_defaults();
        i_reset = 1'b1;
        apply_reset(1'b0);

        // Sequential NOP stream, with a 10-cycle decode hold on the first instruction.
        run_until(1, 20);
        hold_decode = 1'b1;
        repeat (10) step();
        chk("hold_tag", 32'(o_tag), 32'd1);
        chk("hold_no_req", 32'(o_bus_request), 32'd0);
        chk("hold_reqs", 32'(log_addr.size()), 32'd1);
        hold_decode = 1'b0;
        run_until(3, 40);
        repeat (3) step();
        chk("seq_addr0", log_addr[0], 32'h100);
        chk("seq_addr1", log_addr[1], 32'h104);
        chk("seq_addr2", log_addr[2], 32'h108);
        chk("seq_tag0", 32'(log_tag[0]), 32'd1);
        chk("seq_tag1", 32'(log_tag[1]), 32'd2);
        chk("seq_tag2", 32'(log_tag[2]), 32'd3);
        chk("seq_pc2", log_pc[2], 32'h108);
        chk("seq_word0", log_instr[0], 32'h0000_0013);

        // JAL at 0x100: wait for execute, ignore a wrong-tag resolve, continue at 0x180.
        apply_reset(1'b0);
        ovr_addr       = 32'h100;
        ovr_word       = 32'h0080_006F;
        bad_jump       = 1'b1;
        jump_delay_max = 3;
        jump_target    = 32'h180;
        run_until(2, 40);
        repeat (2) step();
        chk("jal_word", log_instr[0], 32'h0080_006F);
        chk("jal_next_addr", log_addr[1], 32'h180);
        chk("jal_next_pc", log_pc[1], 32'h180);
        chk("jal_next_tag", 32'(log_tag[1]), 32'd2);

        // Misaligned resolved pc: fault and halt until reset.
        apply_reset(1'b0);
        bad_jump    = 1'b0;
        jump_target = 32'h182;
        repeat (30) step();
        chk("halt_fault_set", 32'(o_fault), 32'd1);
        chk("halt_req_count", 32'(log_addr.size()), 32'd1);
        chk("halt_req_low", 32'(o_bus_request), 32'd0);

        // Tag wrap across 17 instructions with stalls and bus latency.
        apply_reset(1'b0);
        ovr_addr      = 32'hFFFF_FFFF;
        stall_pct     = 30;
        max_bus_delay = 2;
        run_until(17, 400);
        repeat (3) step();
        chk("wrap_tag14", 32'(log_tag[14]), 32'd15);
        chk("wrap_tag15", 32'(log_tag[15]), 32'd0);
        chk("wrap_tag16", 32'(log_tag[16]), 32'd1);
        chk("wrap_pc16", log_pc[16], 32'h140);

        // Reset while a read is outstanding, with ready in the same cycle.
        apply_reset(1'b0);
        hold_bus = 1'b1;
        for (int k = 0; k < 10 && !req_open; k++) step();
        repeat (2) step();
        chk("wait_req_high", 32'(o_bus_request), 32'd1);
        apply_reset(1'b1);
        hold_bus = 1'b0;
        run_until(1, 20);
        chk("post_rst_addr", log_addr[0], RST_PC);

        // Randomised mixed stream with branches, jumps and stalls.
        apply_reset(1'b0);
        plain_nop      = 1'b0;
        ctrl_mix       = 1'b1;
        jump_rand      = 1'b1;
        bad_jump       = 1'b1;
        stall_pct      = 40;
        max_bus_delay  = 3;
        jump_delay_max = 4;
        repeat (3000) step();
        chk("random_progress", 32'(log_pc.size() > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
